// File: rtl/pvr_pkg.sv
// Shared types and constants for the PVR texture-memory side blocks.
package pvr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam int CB_WORDS = 256;
   localparam int BCNT_W   = 7;

endpackage

// File: rtl/codebook_fetch.sv
// VQ codebook refill fetcher: bursts codebook words out of VRAM and streams
// them to the codebook cache one word per vram_valid pulse.
//
// state | meaning
// IDLE  | waiting for a cache refill request
// REQ   | burst request raised, waiting for mem_ack
// DATA  | draining beats of the accepted burst
// HOLD  | all words delivered, waiting for codebook_wait to fall
module codebook_fetch
   import pvr_pkg::*;
#(
   parameter int BURST_LEN = 8,
   parameter int MEM_AW    = 21
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              codebook_wait,
   input  logic [7:0]        ram_read_offset,
   input  logic [23:0]       cb_base_addr,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [BCNT_W-1:0] mem_burstcnt,
   input  logic              mem_ack,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              vram_valid,
   output logic [63:0]       cache_din,
   output logic              fetch_busy
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [MEM_AW-1:0] cur_addr;
   logic [8:0]        remaining;
   logic [BCNT_W-1:0] beats;
   logic              abort;
   logic [BCNT_W-1:0] burst_len;
   logic              beat;
   logic              last_beat;
   logic              deliver;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^cb_base_addr[2:0];

   always_comb begin
      burst_len = BCNT_W'(BURST_LEN);
      if (remaining < 9'(BURST_LEN))
         burst_len = remaining[BCNT_W-1:0];
   end

   assign beat      = (state == DATA) && mem_rvalid;
   assign last_beat = beat && (beats == BCNT_W'(1));
   // Once the cache has dropped its request, beats are drained silently.
   assign deliver   = beat && codebook_wait && !abort;

   always_comb begin
      state_nxt    = state;
      mem_req      = 1'b0;
      mem_addr     = '0;
      mem_burstcnt = '0;
      fetch_busy   = (state != IDLE);
      case (state)
         IDLE: begin
            if (codebook_wait)
               state_nxt = REQ;
         end
         REQ: begin
            mem_req      = 1'b1;
            mem_addr     = cur_addr;
            mem_burstcnt = burst_len;
            if (mem_ack)
               state_nxt = DATA;
         end
         DATA: begin
            if (last_beat) begin
               if (abort || !codebook_wait)
                  state_nxt = IDLE;
               else if (remaining == 9'd1)
                  state_nxt = HOLD;
               else
                  state_nxt = REQ;
            end
         end
         HOLD: begin
            if (!codebook_wait)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cur_addr   <= '0;
         remaining  <= '0;
         beats      <= '0;
         abort      <= 1'b0;
         vram_valid <= 1'b0;
         cache_din  <= '0;
      end else begin
         state      <= state_nxt;
         vram_valid <= deliver;

         if (state == IDLE && codebook_wait) begin
            cur_addr  <= MEM_AW'(cb_base_addr[23:3]) + MEM_AW'(ram_read_offset);
            remaining <= 9'(CB_WORDS) - {1'b0, ram_read_offset};
            abort     <= 1'b0;
         end

         if ((state == REQ || state == DATA) && !codebook_wait)
            abort <= 1'b1;

         if (state == REQ && mem_ack)
            beats <= burst_len;

         if (beat) begin
            beats     <= beats - BCNT_W'(1);
            remaining <= remaining - 9'd1;
            cur_addr  <= cur_addr + MEM_AW'(1);
         end

         if (deliver)
            cache_din <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_codebook_fetch.sv
// Bench for codebook_fetch: randomized memory responder plus a reference
// model of the expected request list and word stream for each refill.
module tb_codebook_fetch;

   localparam int BL = 8;
   localparam int AW = 21;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          codebook_wait;
   logic [7:0]    ram_read_offset;
   logic [23:0]   cb_base_addr;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [6:0]    mem_burstcnt;
   logic          mem_ack;
   logic [63:0]   mem_rdata;
   logic          mem_rvalid;
   logic          vram_valid;
   logic [63:0]   cache_din;
   logic          fetch_busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      int            cnt;
   } req_t;

   codebook_fetch #(.BURST_LEN(BL), .MEM_AW(AW)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .codebook_wait   (codebook_wait),
      .ram_read_offset (ram_read_offset),
      .cb_base_addr    (cb_base_addr),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_burstcnt    (mem_burstcnt),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .mem_rvalid      (mem_rvalid),
      .vram_valid      (vram_valid),
      .cache_din       (cache_din),
      .fetch_busy      (fetch_busy)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // VRAM contents: a recognisable pattern derived from the word address.
   function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
      return {11'h5A3, a, ~a, 11'h0C7};
   endfunction

   task automatic run_refill(input logic [23:0] base, input logic [7:0] off,
                             input int stall_lo, input int stall_hi, input int gap_pct,
                             input int drop_beat, input int rst_beat);
      logic [AW-1:0] start_addr, a, burst_addr, req_addr_s;
      logic [6:0]    req_cnt_s;
      logic [63:0]   exp_words[$];
      req_t          exp_req[$];
      req_t          r;
      int total, rem, delivered, sent, burst_left, stall, cyc;
      bit in_burst, req_seen, prev_exp, dropped, finished;

      start_addr = base[23:3] + AW'(off);
      total      = 256 - int'(off);
      for (int i = 0; i < total; i++)
         exp_words.push_back(mem_word(start_addr + AW'(i)));
      rem = total;
      a   = start_addr;
      while (rem > 0) begin
         r.addr = a;
         r.cnt  = (rem < BL) ? rem : BL;
         exp_req.push_back(r);
         a   = a + AW'(r.cnt);
         rem = rem - r.cnt;
      end

      delivered = 0; sent = 0; burst_left = 0; stall = 0;
      in_burst = 0; req_seen = 0; prev_exp = 0; dropped = 0; finished = 0;
      burst_addr = '0; req_addr_s = '0; req_cnt_s = '0;
      cb_base_addr    = base;
      ram_read_offset = off;
      codebook_wait   = 1'b1;

      for (cyc = 0; cyc < 6000 && !finished; cyc++) begin
         @(negedge clock);
         if (vram_valid || prev_exp)
            check_eq("vv_latency", 64'(vram_valid), 64'(prev_exp));
         if (vram_valid) begin
            if (delivered < total)
               check_eq("word", cache_din, exp_words[delivered]);
            else
               check_eq("word_count", 64'(delivered + 1), 64'(total));
            delivered++;
         end
         mem_ack    = 1'b0;
         mem_rvalid = 1'b0;
         prev_exp   = 1'b0;

         if (!in_burst && (dropped || delivered == total)) begin
            finished = 1;
         end else if (mem_req && !in_burst) begin
            if (!req_seen) begin
               req_seen = 1;
               if (exp_req.size() == 0) begin
                  check_eq("extra_req", 64'(mem_req), 64'(0));
               end else begin
                  r = exp_req.pop_front();
                  check_eq("req_addr", 64'(mem_addr), 64'(r.addr));
                  check_eq("req_cnt", 64'(mem_burstcnt), 64'(r.cnt));
               end
               req_addr_s = mem_addr;
               req_cnt_s  = mem_burstcnt;
               stall      = int'($urandom_range(stall_hi, stall_lo));
            end else begin
               check_eq("req_stable", {36'(mem_addr), 28'(mem_burstcnt)},
                        {36'(req_addr_s), 28'(req_cnt_s)});
            end
            if (stall == 0) begin
               mem_ack    = 1'b1;
               in_burst   = 1;
               burst_left = int'(req_cnt_s);
               burst_addr = req_addr_s;
               req_seen   = 0;
            end else begin
               stall--;
            end
         end else if (in_burst && int'($urandom_range(99, 0)) >= gap_pct) begin
            if (sent == rst_beat) begin
               reset_n = 1'b0;
               #1;
               check_eq("rst_mem_req", 64'(mem_req), 64'(0));
               check_eq("rst_vram_valid", 64'(vram_valid), 64'(0));
               check_eq("rst_busy", 64'(fetch_busy), 64'(0));
               check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
               check_eq("rst_cache_din", cache_din, 64'(0));
               return;
            end
            if (sent == drop_beat) begin
               codebook_wait = 1'b0;
               dropped       = 1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(burst_addr);
            burst_addr = burst_addr + AW'(1);
            burst_left--;
            if (burst_left == 0)
               in_burst = 0;
            prev_exp = codebook_wait;
            sent++;
         end
      end

      if (!finished) begin
         check_eq("timeout_delivered", 64'(delivered), 64'(total));
         return;
      end

      if (dropped) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_eq("drop_no_req", 64'(mem_req), 64'(0));
            check_eq("drop_no_valid", 64'(vram_valid), 64'(0));
         end
         check_eq("drop_idle", 64'(fetch_busy), 64'(0));
         check_eq("drop_delivered", 64'(delivered), 64'(drop_beat));
      end else begin
         check_eq("req_all_issued", 64'(exp_req.size()), 64'(0));
         for (int i = 0; i < 3; i++) begin
            check_eq("hold_busy", 64'(fetch_busy), 64'(1));
            check_eq("hold_no_req", 64'(mem_req), 64'(0));
            @(negedge clock);
            check_eq("hold_no_valid", 64'(vram_valid), 64'(0));
         end
         // A stray beat while leaving HOLD and another in IDLE must be ignored.
         mem_rvalid    = 1'b1;
         mem_rdata     = {$urandom, $urandom};
         codebook_wait = 1'b0;
         @(negedge clock);
         check_eq("idle_after_hold", 64'(fetch_busy), 64'(0));
         check_eq("stray_hold_valid", 64'(vram_valid), 64'(0));
         @(negedge clock);
         mem_rvalid = 1'b0;
         check_eq("stray_idle_valid", 64'(vram_valid), 64'(0));
         check_eq("stray_idle_busy", 64'(fetch_busy), 64'(0));
      end
      @(negedge clock);
   endtask

   initial begin
      reset_n         = 1'b0;
      codebook_wait   = 1'b0;
      ram_read_offset = '0;
      cb_base_addr    = '0;
      mem_ack         = 1'b0;
      mem_rdata       = '0;
      mem_rvalid      = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("reset_mem_req", 64'(mem_req), 64'(0));
      check_eq("reset_mem_addr", 64'(mem_addr), 64'(0));
      check_eq("reset_burstcnt", 64'(mem_burstcnt), 64'(0));
      check_eq("reset_vram_valid", 64'(vram_valid), 64'(0));
      check_eq("reset_cache_din", cache_din, 64'(0));
      check_eq("reset_busy", 64'(fetch_busy), 64'(0));
      reset_n = 1'b1;
      @(negedge clock);

      run_refill(24'h100000, 8'd0, 0, 0, 0, -1, -1);
      run_refill(24'h100000, 8'd250, 0, 0, 0, -1, -1);
      run_refill(24'h345678, 8'd0, 5, 5, 40, -1, -1);
      run_refill(24'hFFFFF8, 8'd0, 0, 2, 20, -1, -1);

      run_refill(24'h2A0000, 8'd0, 0, 1, 0, -1, 3 * BL + 2);
      @(negedge clock);
      ram_read_offset = 8'd100;
      reset_n         = 1'b1;
      run_refill(24'h2A0000, 8'd100, 0, 1, 10, -1, -1);

      run_refill(24'h0A0A08, 8'd0, 0, 2, 20, BL + 3, -1);

      for (int t = 0; t < 3; t++)
         run_refill(24'($urandom), 8'($urandom_range(255, 0)), 0, 3, 30, -1, -1);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/codebook_fetch.md
Name: codebook_fetch

Overview:
- VRAM-side fetcher that sits directly upstream of the VQ codebook cache and services its refills.
- When the cache raises codebook_wait, the block reads the 256-word (64-bit) codebook for the current texture from VRAM.
- Reads are issued as fixed-length bursts on the PVR memory port.
- Returned words are streamed to the cache in order, one vram_valid pulse per word, matching the cache's word_index progression.

Parameters:
- BURST_LEN, 8, words per memory burst; power of two, 1..64.
- MEM_AW, 21, memory word-address width (64-bit words).
- CB_WORDS, 256, codebook size in 64-bit words; fixed.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- codebook_wait  in  1  cache refill request; high until the cache has received its last word.
- ram_read_offset  in  8  cache's next-expected word index; sampled at refill start (normally 0).
- cb_base_addr  in  24  VRAM byte address of codebook; bits [2:0] ignored; sampled at refill start.
- mem_req  out  1  burst request; held until accepted.
- mem_addr  out  MEM_AW  burst start word address.
- mem_burstcnt  out  7  beats in this burst (1..BURST_LEN).
- mem_ack  in  1  request accepted this cycle (qualifies mem_req).
- mem_rdata  in  64  read beat data.
- mem_rvalid  in  1  read beat valid.
- vram_valid  out  1  one-cycle pulse: cache_din holds the next codebook word.
- cache_din  out  64  codebook word to the cache.
- fetch_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-low) drives the following and aborts any fetch in progress:
  - state = IDLE; mem_req, vram_valid and fetch_busy = 0.
  - mem_addr, mem_burstcnt and cache_din = 0.
  - Internal counters = 0.
  - The memory controller shares the same reset, so no stale beats arrive afterwards.
- Internal registers:
  - cur_addr, MEM_AW bits.
  - remaining, 9 bits, words still to deliver.
  - beats, 7 bits, beats outstanding in the current burst.
- IDLE:
  - If codebook_wait = 1, latch cur_addr = cb_base_addr[23:3] + ram_read_offset, modulo 2^MEM_AW (wraps; no error).
  - Latch remaining = 256 − ram_read_offset (range 1..256), then go to REQ.
- REQ:
  - mem_req = 1, mem_addr = cur_addr, mem_burstcnt = min(BURST_LEN, remaining).
  - Address and count stay stable while mem_req is high and mem_ack is low.
  - On mem_ack: load beats = mem_burstcnt, drop mem_req next cycle, go to DATA.
  - Only one burst is outstanding at a time.
- DATA, on each mem_rvalid:
  - Register cache_din = mem_rdata and pulse vram_valid = 1 the next cycle (latency exactly 1 clock).
  - Decrement beats and remaining; increment cur_addr.
  - On the last beat of a burst: if remaining becomes 0, go to HOLD; otherwise go to REQ. The next request is raised the cycle after the last beat.
  - mem_rvalid outside DATA is ignored: no vram_valid, no counter change.
- HOLD:
  - Wait for codebook_wait = 0, then go to IDLE.
  - This prevents a retrigger in the cycle where the cache's word_index reaches 256 one clock after the final vram_valid.
  - A new refill needs codebook_wait to fall and rise again. Minimum gap between refills: 1 IDLE cycle.
- codebook_wait dropping in REQ or DATA (cache reset or clear race):
  - The current burst completes and its beats are still drained.
  - vram_valid is suppressed for those beats.
  - The block then goes to IDLE with no new request.
- Back-to-back mem_rvalid on consecutive cycles gives back-to-back vram_valid pulses; no buffering beyond the 1-stage register.
- Full codebook refill: 256/BURST_LEN bursts (32 at the default).

Decomposition:
- Shared package pvr_pkg holds:
  - the state enum {IDLE, REQ, DATA, HOLD};
  - the CB_WORDS constant;
  - the memory-port burst-count width.
- No sub-module: a single FSM plus counters.

Test Plan:
- Basic refill: cb_base_addr=0x100000, offset 0, mem_ack immediate, rvalid every cycle.
  - Expect 32 requests at word addresses 0x20000, 0x20008, …, each with burstcnt 8.
  - Expect exactly 256 vram_valid pulses carrying data in address order.
  - Expect HOLD, then IDLE after codebook_wait falls.
- Partial start: ram_read_offset=250.
  - Expect one burst of 6 words at base+250 and 6 vram_valid pulses, then HOLD.
- Backpressure: mem_ack held low 5 cycles, rvalid gapped randomly.
  - Expect mem_addr and burstcnt stable during the stall.
  - Expect each vram_valid exactly 1 cycle after its mem_rvalid.
  - Expect no duplicate or missing words.
- Address wrap: cb_base_addr=0xFFFFF8, offset 0.
  - Expect the first burst at 0x1FFFFF with burstcnt 8 (cur_addr wraps to 0 inside the burst).
  - Expect the second burst at 0x000007.
- Reset mid-burst: assert reset_n=0 at the 3rd beat of burst 4.
  - Expect immediately: mem_req, vram_valid and fetch_busy = 0; state IDLE.
  - After release with codebook_wait high, expect a restart from the newly sampled offset.
- Wait drop: codebook_wait falls during DATA of burst 2.
  - Expect the remaining beats consumed with no vram_valid.
  - Expect no further mem_req, then IDLE.
